// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the control sequencer: the state enum, the
//   instruction opcodes, the bit position of each ALU operation inside the
//   one-hot ALUControl word, and two helpers that classify an opcode and
//   build its ALUControl word.
package cpu_pkg;

    typedef enum logic [3:0] {
        IDLE,
        T0,
        T1,
        T2,
        T3,
        T4,
        T5,
        T6,
        HALTED
    } state_t;

    localparam logic [4:0] OP_AND  = 5'b00001;
    localparam logic [4:0] OP_OR   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_NOT  = 5'b01001;
    localparam logic [4:0] OP_NEG  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11001;

    localparam int ALU_W   = 12;
    localparam int ALU_AND = 0;
    localparam int ALU_OR  = 1;
    localparam int ALU_ADD = 2;
    localparam int ALU_SUB = 3;
    localparam int ALU_SHR = 4;
    localparam int ALU_SHL = 5;
    localparam int ALU_ROR = 6;
    localparam int ALU_ROL = 7;
    localparam int ALU_NEG = 8;
    localparam int ALU_MUL = 9;
    localparam int ALU_DIV = 10;
    localparam int ALU_NOT = 11;

    // Execution shape of an instruction after the common fetch.
    typedef enum logic [2:0] {
        C_BIN,      // Rb -> Y, Rc op Y -> Z, Zlo -> Ra
        C_UNARY,    // op Rb -> Z, Zlo -> Ra
        C_MULDIV,   // Ra -> Y, Rb op Y -> Z, Zlo -> LO, Zhi -> HI
        C_NOP,
        C_HALT,
        C_ILLEGAL
    } op_class_t;

    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t c;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: c = C_BIN;
            OP_NOT, OP_NEG:                 c = C_UNARY;
            OP_MUL, OP_DIV:                 c = C_MULDIV;
            OP_NOP:                         c = C_NOP;
            OP_HALT:                        c = C_HALT;
            default:                        c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic logic [ALU_W-1:0] alu_onehot(input logic [4:0] op);
        logic [ALU_W-1:0] r;
        r = '0;
        case (op)
            OP_AND:  r[ALU_AND] = 1'b1;
            OP_OR:   r[ALU_OR]  = 1'b1;
            OP_ADD:  r[ALU_ADD] = 1'b1;
            OP_SUB:  r[ALU_SUB] = 1'b1;
            OP_SHR:  r[ALU_SHR] = 1'b1;
            OP_SHL:  r[ALU_SHL] = 1'b1;
            OP_ROR:  r[ALU_ROR] = 1'b1;
            OP_ROL:  r[ALU_ROL] = 1'b1;
            OP_NOT:  r[ALU_NOT] = 1'b1;
            OP_NEG:  r[ALU_NEG] = 1'b1;
            OP_MUL:  r[ALU_MUL] = 1'b1;
            OP_DIV:  r[ALU_DIV] = 1'b1;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sel_encode.sv
// sel_encode
//   Picks one of the three register fields of the instruction (Ra, Rb or Rc,
//   chosen by Gra/Grb/Grc in that priority) and turns it into a one-hot
//   register-file enable on Rin_vec and/or Rout_vec.
// Ports
//   Gra, Grb, Grc : field select (Ra / Rb / Rc)
//   Rin, Rout     : drive the decoded register onto Rin_vec / Rout_vec
//   ra, rb, rc    : register fields IR[26:23], IR[22:19], IR[18:15]
//   Rin_vec       : one-hot write enable, R0 = bit0 (zero when Rin=0)
//   Rout_vec      : one-hot read enable,  R0 = bit0 (zero when Rout=0)
module sel_encode (
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        Rin,
    input  logic        Rout,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [3:0]  rc,
    output logic [15:0] Rin_vec,
    output logic [15:0] Rout_vec
);

    logic [3:0]  sel;
    logic [15:0] dec;

    always_comb begin
        sel = '0;
        if (Gra)
            sel = ra;
        else if (Grb)
            sel = rb;
        else if (Grc)
            sel = rc;
        dec      = 16'd1 << sel;
        Rin_vec  = Rin  ? dec : '0;
        Rout_vec = Rout ? dec : '0;
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   Hard-wired control unit. A single state register walks IDLE -> T0..T6
//   (one clk per T-state) and every strobe is decoded combinationally from
//   the current state and IR. T0..T2 fetch the instruction; T3 onwards
//   execute it according to its opcode class. HALT parks the unit in HALTED
//   until clr.
// Ports
//   clk        : system clock, rising edge
//   clr        : asynchronous active-high reset, forces IDLE
//   run        : allows a new fetch (IDLE->T0, or end of instruction->T0)
//   IR         : instruction; opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15]
//   PCout..HIin: datapath strobes, active high
//   ALUControl : one-hot ALU operation, nonzero only in the ALU state
//   Rin_vec    : one-hot register write enable
//   Rout_vec   : one-hot register read enable
//   halted     : high while parked after HALT
//   illegal    : one-cycle pulse in T3 for an unknown opcode
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRRead,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        LOin,
    output logic        HIin,
    output logic [11:0] ALUControl,
    output logic [15:0] Rin_vec,
    output logic [15:0] Rout_vec,
    output logic        halted,
    output logic        illegal
);

    state_t    state, state_nx, wrap;
    op_class_t cls;
    logic      gra, grb, grc, rin, rout;
    logic      unused_ir;

    // IR[14:0] carries immediates the sequencer never looks at.
    assign unused_ir = ^IR[14:0];
    assign cls       = classify(IR[31:27]);
    assign wrap      = run ? T0 : IDLE;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // The opcode is only trusted from T3 on: IR is loaded by the IRin edge
    // that ends T2, so even NOP and unknown opcodes pass through T3 (with no
    // strobes, apart from the illegal pulse) before the sequencer returns.
    always_comb begin
        state_nx   = state;
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        Zin        = 1'b0;
        PCin       = 1'b0;
        MDRRead    = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        LOin       = 1'b0;
        HIin       = 1'b0;
        ALUControl = '0;
        halted     = 1'b0;
        illegal    = 1'b0;
        gra        = 1'b0;
        grb        = 1'b0;
        grc        = 1'b0;
        rin        = 1'b0;
        rout       = 1'b0;

        case (state)
            IDLE: if (run) state_nx = T0;
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                state_nx = T1;
            end
            T1: begin
                Zlowout = 1'b1; PCin = 1'b1; MDRRead = 1'b1; MDRin = 1'b1;
                state_nx = T2;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                state_nx = T3;
            end
            T3: begin
                case (cls)
                    C_BIN: begin
                        grb = 1'b1; rout = 1'b1; Yin = 1'b1;
                        state_nx = T4;
                    end
                    C_UNARY: begin
                        grb = 1'b1; rout = 1'b1; Zin = 1'b1;
                        ALUControl = alu_onehot(IR[31:27]);
                        state_nx = T4;
                    end
                    C_MULDIV: begin
                        gra = 1'b1; rout = 1'b1; Yin = 1'b1;
                        state_nx = T4;
                    end
                    C_HALT:    state_nx = HALTED;
                    C_ILLEGAL: begin
                        illegal  = 1'b1;
                        state_nx = wrap;
                    end
                    default:   state_nx = wrap;
                endcase
            end
            T4: begin
                case (cls)
                    C_BIN: begin
                        grc = 1'b1; rout = 1'b1; Zin = 1'b1;
                        ALUControl = alu_onehot(IR[31:27]);
                        state_nx = T5;
                    end
                    C_UNARY: begin
                        Zlowout = 1'b1; gra = 1'b1; rin = 1'b1;
                        state_nx = wrap;
                    end
                    C_MULDIV: begin
                        grb = 1'b1; rout = 1'b1; Zin = 1'b1;
                        ALUControl = alu_onehot(IR[31:27]);
                        state_nx = T5;
                    end
                    default: state_nx = wrap;
                endcase
            end
            T5: begin
                case (cls)
                    C_BIN: begin
                        Zlowout = 1'b1; gra = 1'b1; rin = 1'b1;
                        state_nx = wrap;
                    end
                    C_MULDIV: begin
                        Zlowout = 1'b1; LOin = 1'b1;
                        state_nx = T6;
                    end
                    default: state_nx = wrap;
                endcase
            end
            T6: begin
                Zhighout = 1'b1; HIin = 1'b1;
                state_nx = wrap;
            end
            HALTED: begin
                halted   = 1'b1;
                state_nx = HALTED;
            end
            default: state_nx = IDLE;
        endcase
    end

    sel_encode u_sel (
        .Gra      (gra),
        .Grb      (grb),
        .Grc      (grc),
        .Rin      (rin),
        .Rout     (rout),
        .ra       (IR[26:23]),
        .rb       (IR[22:19]),
        .rc       (IR[18:15]),
        .Rin_vec  (Rin_vec),
        .Rout_vec (Rout_vec)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Drives directed and random instructions into control_sequencer and
//   compares every cycle's outputs with an expected per-cycle trace built
//   from the instruction's opcode class and register fields.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        run;
    logic [31:0] IR;
    logic        PCout, MARin, IncPC, Zin, PCin, MDRRead, MDRin, MDRout, IRin;
    logic        Yin, Zlowout, Zhighout, LOin, HIin;
    logic [11:0] ALUControl;
    logic [15:0] Rin_vec, Rout_vec;
    logic        halted, illegal;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk        (clk),
        .clr        (clr),
        .run        (run),
        .IR         (IR),
        .PCout      (PCout),
        .MARin      (MARin),
        .IncPC      (IncPC),
        .Zin        (Zin),
        .PCin       (PCin),
        .MDRRead    (MDRRead),
        .MDRin      (MDRin),
        .MDRout     (MDRout),
        .IRin       (IRin),
        .Yin        (Yin),
        .Zlowout    (Zlowout),
        .Zhighout   (Zhighout),
        .LOin       (LOin),
        .HIin       (HIin),
        .ALUControl (ALUControl),
        .Rin_vec    (Rin_vec),
        .Rout_vec   (Rout_vec),
        .halted     (halted),
        .illegal    (illegal)
    );

    typedef struct packed {
        logic [13:0] strb;
        logic        halted;
        logic        illegal;
        logic [11:0] alu;
        logic [15:0] rin;
        logic [15:0] rout;
    } obs_t;

    localparam logic [13:0] S_PCOUT   = 14'h2000;
    localparam logic [13:0] S_MARIN   = 14'h1000;
    localparam logic [13:0] S_INCPC   = 14'h0800;
    localparam logic [13:0] S_ZIN     = 14'h0400;
    localparam logic [13:0] S_PCIN    = 14'h0200;
    localparam logic [13:0] S_MDRREAD = 14'h0100;
    localparam logic [13:0] S_MDRIN   = 14'h0080;
    localparam logic [13:0] S_MDROUT  = 14'h0040;
    localparam logic [13:0] S_IRIN    = 14'h0020;
    localparam logic [13:0] S_YIN     = 14'h0010;
    localparam logic [13:0] S_ZLOW    = 14'h0008;
    localparam logic [13:0] S_ZHIGH   = 14'h0004;
    localparam logic [13:0] S_LOIN    = 14'h0002;
    localparam logic [13:0] S_HIIN    = 14'h0001;

    obs_t obs;
    assign obs = {PCout, MARin, IncPC, Zin, PCin, MDRRead, MDRin, MDRout, IRin,
                  Yin, Zlowout, Zhighout, LOin, HIin, halted, illegal,
                  ALUControl, Rin_vec, Rout_vec};

    int   n_checks = 0;
    int   n_pass   = 0;
    obs_t exp_q[$];
    bit   exp_halt;

    task automatic check(input string tag, input logic [59:0] got, input logic [59:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic obs_t mk(input logic [13:0] s, input logic [11:0] a,
                                input logic [15:0] ri, input logic [15:0] ro);
        obs_t o;
        o      = '0;
        o.strb = s;
        o.alu  = a;
        o.rin  = ri;
        o.rout = ro;
        return o;
    endfunction

    // ALUControl bit for each ALU opcode; -1 for everything else.
    function automatic int alu_bit(input logic [4:0] op);
        case (op)
            5'd1:  return 0;   // AND
            5'd2:  return 1;   // OR
            5'd3:  return 2;   // ADD
            5'd4:  return 3;   // SUB
            5'd5:  return 4;   // SHR
            5'd6:  return 5;   // SHL
            5'd7:  return 6;   // ROR
            5'd8:  return 7;   // ROL
            5'd9:  return 11;  // NOT
            5'd10: return 8;   // NEG
            5'd11: return 9;   // MUL
            5'd12: return 10;  // DIV
            default: return -1;
        endcase
    endfunction

    // Expected output of every cycle from T0 to the last state of ir.
    task automatic build(input logic [31:0] ir);
        logic [4:0]  op;
        logic [15:0] ma, mb, mc;
        logic [11:0] al;
        obs_t        o;
        int          b;
        op = ir[31:27];
        ma = 16'd1 << ir[26:23];
        mb = 16'd1 << ir[22:19];
        mc = 16'd1 << ir[18:15];
        b  = alu_bit(op);
        al = (b >= 0) ? (12'd1 << b) : 12'd0;
        exp_q.delete();
        exp_halt = 1'b0;
        exp_q.push_back(mk(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, '0, '0, '0));
        exp_q.push_back(mk(S_ZLOW | S_PCIN | S_MDRREAD | S_MDRIN, '0, '0, '0));
        exp_q.push_back(mk(S_MDROUT | S_IRIN, '0, '0, '0));
        if (op >= 5'd1 && op <= 5'd8) begin
            exp_q.push_back(mk(S_YIN, '0, '0, mb));
            exp_q.push_back(mk(S_ZIN, al, '0, mc));
            exp_q.push_back(mk(S_ZLOW, '0, ma, '0));
        end else if (op == 5'd9 || op == 5'd10) begin
            exp_q.push_back(mk(S_ZIN, al, '0, mb));
            exp_q.push_back(mk(S_ZLOW, '0, ma, '0));
        end else if (op == 5'd11 || op == 5'd12) begin
            exp_q.push_back(mk(S_YIN, '0, '0, ma));
            exp_q.push_back(mk(S_ZIN, al, '0, mb));
            exp_q.push_back(mk(S_ZLOW | S_LOIN, '0, '0, '0));
            exp_q.push_back(mk(S_ZHIGH | S_HIIN, '0, '0, '0));
        end else if (op == 5'd24) begin
            exp_q.push_back('0);
        end else if (op == 5'd25) begin
            exp_q.push_back('0);
            o        = '0;
            o.halted = 1'b1;
            for (int k = 0; k < 22; k++) exp_q.push_back(o);
            exp_halt = 1'b1;
        end else begin
            o         = '0;
            o.illegal = 1'b1;
            exp_q.push_back(o);
        end
    endtask

    // Entered with run=1 so the next rising edge starts T0. abort_at >= 0
    // raises clr between edges right after that step has been checked.
    task automatic run_instr(input logic [31:0] ir, input bit run_after,
                             input int gap, input int abort_at);
        @(posedge clk);
        #1;
        IR = ir;
        build(ir);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check($sformatf("op%02h_ir%08h_step%0d", ir[31:27], ir, i), obs, exp_q[i]);
            if (i == abort_at) begin
                #2 clr = 1'b1;
                #1 check("async_clr_mid_instr", obs, '0);
                @(negedge clk);
                check("held_in_clr", obs, '0);
                clr = 1'b0;
                run = 1'b1;
                return;
            end
            if (i == exp_q.size() - 1 && !exp_halt)
                run = run_after;
        end
        if (exp_halt) begin
            #2 clr = 1'b1;
            #1 check("halt_clr_async", obs, '0);
            @(negedge clk);
            check("halt_clr_held", obs, '0);
            clr = 1'b0;
            run = 1'b1;
            return;
        end
        if (!run_after) begin
            for (int g = 0; g <= gap; g++) begin
                @(negedge clk);
                check("idle_no_run", obs, '0);
            end
            run = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] rnd;
        logic [4:0]  op;
        int          r;
        clr = 1'b1;
        run = 1'b0;
        IR  = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", obs, '0);
        run = 1'b1;
        #1 check("reset_run_high", obs, '0);
        @(negedge clk);
        check("reset_after_edge", obs, '0);
        clr = 1'b0;

        run_instr(32'h4A920000, 1'b1, 0, -1);   // NOT R5,R2: T4 on 5th edge
        run_instr(32'h18918000, 1'b1, 0, -1);   // ADD R1,R2,R3
        run_instr(32'h5A300000, 1'b0, 2, -1);   // MUL R4,R6, then idle
        run_instr(32'hF8000000, 1'b1, 0, -1);   // unknown opcode 11111
        run_instr(32'hC0000000, 1'b1, 0, -1);   // NOP
        run_instr(32'h18918000, 1'b1, 0, 4);    // ADD, clr during T4
        run_instr(32'h18918000, 1'b1, 0, -1);   // refetch after clr

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 15);
            if (r <= 11)
                op = 5'(r + 1);
            else if (r == 12)
                op = 5'd24;
            else begin
                r = $urandom_range(0, 17);
                if (r == 0)
                    op = 5'd0;
                else if (r <= 11)
                    op = 5'(12 + r);
                else
                    op = 5'(14 + r);
            end
            rnd = $urandom();
            run_instr({op, rnd[26:0]}, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), -1);
        end

        run_instr(32'hC8000000, 1'b1, 0, -1);   // HALT, then clr
        run_instr(32'h18918000, 1'b0, 1, -1);   // fetch resumes after clr

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port clr, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port run, input, 1 bit: permits a new fetch when high.
REQ-004 SHALL have port IR, input, 32 bits: instruction register contents; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-005 SHALL have 1-bit outputs PCout, MARin, IncPC, Zin, PCin, MDRRead, MDRin, MDRout, IRin, Yin, Zlowout, Zhighout, LOin, HIin: datapath strobes, high = asserted.
REQ-006 SHALL have port ALUControl, output, 12 bits: one-hot ALU op; bit0 AND, bit1 OR, bit2 ADD, bit3 SUB, bit4 SHR, bit5 SHL, bit6 ROR, bit7 ROL, bit8 NEG, bit9 MUL, bit10 DIV, bit11 NOT.
REQ-007 SHALL have ports Rin_vec and Rout_vec, output, 16 bits each: one-hot register-file enables, R0 = bit0.
REQ-008 SHALL have ports halted and illegal, output, 1 bit each: HALT reached; unknown opcode, one-cycle pulse.

Function
REQ-009 SHALL implement states IDLE, T0..T6 and HALTED; each T-state lasts exactly one clk cycle.
REQ-010 SHALL move IDLE->T0 when run=1; otherwise remain in IDLE.
REQ-011 SHALL assert PCout, MARin, IncPC, Zin in T0; Zlowout, PCin, MDRRead, MDRin in T1; MDRout, IRin in T2.
REQ-012 SHALL decode opcodes AND=00001, OR=00010, ADD=00011, SUB=00100, SHR=00101, SHL=00110, ROR=00111, ROL=01000, NOT=01001, NEG=01010, MUL=01011, DIV=01100, NOP=11000, HALT=11001.
REQ-013 SHALL, for binary ops AND..ROL, sequence T3: Rb Rout + Yin; T4: Rc Rout + ALUControl + Zin; T5: Zlowout + Ra Rin.
REQ-014 SHALL, for NOT/NEG, sequence T3: Rb Rout + ALUControl + Zin; T4: Zlowout + Ra Rin.
REQ-015 SHALL, for MUL/DIV, sequence T3: Ra Rout + Yin; T4: Rb Rout + ALUControl + Zin; T5: Zlowout + LOin; T6: Zhighout + HIin.
REQ-016 SHALL return after the last instruction state to T0 if run=1, else IDLE.
REQ-017 SHALL treat NOP as complete after T2.
REQ-018 SHALL treat an unknown opcode as NOP and pulse illegal for one cycle in T3.
REQ-019 SHALL enter HALTED from T3 on HALT, hold halted=1 with all strobes 0, and leave HALTED only through clr.
REQ-020 SHALL decode every output combinationally from the current state and IR (Moore style), with no other internal latency.
REQ-021 SHALL keep Rin_vec and Rout_vec at most one-hot and zero outside the states listed above.
REQ-022 SHALL drive ALUControl nonzero only in its ALU state, holding exactly one bit set there.

Reset
REQ-023 SHALL, while clr=1, force state IDLE immediately (asynchronously), regardless of current state, including mid-instruction.
REQ-024 SHALL hold every output at 0 during reset and in IDLE.
REQ-025 SHALL take the first T0 on the first rising edge after clr falls with run=1.

Structure
REQ-026 SHALL take opcode constants, ALU one-hot bit indices and the state enum from a shared package cpu_pkg.
REQ-027 SHALL contain one sub-module, sel_encode, mapping Gra/Grb/Grc/Rin/Rout and IR fields to Rin_vec/Rout_vec.
REQ-028 SHALL hold the state in a single register; no other storage.

Verification
REQ-029 NOT R5,R2 (IR=0x4A920000), run=1 -> T3: Rout_vec=0x0004, ALUControl=0x800, Zin=1; T4: Zlowout=1, Rin_vec=0x0020; T4 occurs 5 edges after clr falls.
REQ-030 ADD R1,R2,R3 (IR=0x18918000) -> T3: Rout_vec=0x0004, Yin=1; T4: Rout_vec=0x0008, ALUControl=0x004; T5: Rin_vec=0x0002; next cycle T0.
REQ-031 MUL R4,R6 (IR=0x5A300000) -> T5: Zlowout=1, LOin=1; T6: Zhighout=1, HIin=1; Rin_vec=0 throughout.
REQ-032 HALT (IR=0xC8000000) -> halted=1 from the cycle after T3, all strobes 0 for 20+ cycles; clr pulse -> IDLE, halted=0.
REQ-033 clr asserted mid-T4 of ADD -> all outputs 0 immediately without waiting for clk; restart fetch at T0.
REQ-034 IR opcode 11111 -> illegal=1 for exactly one cycle in T3; next instruction T0 follows.
